// File: rtl/traffic_pkg.sv
// Shared traffic-controller definitions: side-road lamp encodings and the
// vehicle request detector state enumeration.
package traffic_pkg;

   // One-hot lamp codes as seen on SideLights: {red, yellow, green}
   localparam logic [2:0] LIGHT_GREEN  = 3'b001;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_RED    = 3'b100;

   // Request detector states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      SERVED = 2'd2
   } det_state_e;

   // True only for an exact lamp code; yellow and any non-one-hot
   // pattern never match green or red, so they cause no transition.
   function automatic logic light_is(input logic [2:0] lights,
                                     input logic [2:0] code);
      return (lights == code);
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a level debouncer. The debounced
// level only follows the synchronised input after it has disagreed for
// DEBOUNCE_CYCLES consecutive cycles; any shorter glitch is discarded.
// Written generically so a pedestrian push-button can reuse it.
module sensor_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic sensor_raw,
   output logic deb
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta_q, meta_d;
   logic             sync_q, sync_d;
   logic             deb_q,  deb_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;

   // Next-state: shift the synchroniser, count disagreement, flip when
   // the disagreement has lasted long enough.
   always_comb begin
      meta_d = sensor_raw;
      sync_d = meta_q;
      deb_d  = deb_q;
      cnt_d  = '0;
      if (sync_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         deb_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         deb_q  <= deb_d;
         cnt_q  <= cnt_d;
      end
   end

   assign deb = deb_q;

endmodule

// File: rtl/vehicle_request_detector.sv
// Side-road vehicle request detector. Debounces the loop sensor, latches
// a request (VehiclePresent) until the side road shows green, and reports
// how many cycles the request waited (saturating).
// Optional stuck-sensor detection is built when VEHICLE_STUCK_DETECT_EN is
// defined; otherwise SensorFault is tied low and no stuck counter exists.
module vehicle_request_detector
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int WAIT_W          = 16,
   parameter int STUCK_CYCLES    = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SensorRaw,
   input  logic [2:0]        SideLights,
   output logic              VehiclePresent,
   output logic [WAIT_W-1:0] WaitCycles,
   output logic              SensorFault
);

   localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

   logic deb;
   logic fault_d;

   det_state_e        state_q, state_d;
   logic              vp_q,    vp_d;
   logic [WAIT_W-1:0] wait_q,  wait_d;

   sensor_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_deb (
      .clk        (clk),
      .rst        (rst),
      .sensor_raw (SensorRaw),
      .deb        (deb)
   );

`ifdef VEHICLE_STUCK_DETECT_EN
   localparam int SC_W = $clog2(STUCK_CYCLES + 1);
   localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STUCK_CYCLES);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(STUCK_CYCLES - 1);

   logic [SC_W-1:0] scnt_q, scnt_d;
   logic            fault_q;

   // Count continuous debounced-high cycles; the fault latches on the
   // STUCK_CYCLES-th one and drops as soon as the sensor reads low.
   always_comb begin
      scnt_d  = '0;
      fault_d = 1'b0;
      if (deb) begin
         scnt_d  = (scnt_q == SC_MAX) ? scnt_q : scnt_q + 1'b1;
         fault_d = fault_q | (scnt_q == SC_LAST);
      end
   end

   // Stuck-detect registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scnt_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         scnt_q  <= scnt_d;
         fault_q <= fault_d;
      end
   end

   assign SensorFault = fault_q;
`else
   assign fault_d     = 1'b0;
   assign SensorFault = 1'b0;
`endif

   // Request FSM next-state plus wait counter; a fault pins the FSM in IDLE.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      unique case (state_q)
         IDLE:    if (deb) state_d = REQ;
         REQ:     if (light_is(SideLights, LIGHT_GREEN)) state_d = SERVED;
         SERVED:  if (light_is(SideLights, LIGHT_RED)) state_d = deb ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
      if (fault_d) state_d = IDLE;
      // Wait counter reloads on entry to REQ and saturates while waiting;
      // it holds across the exit edge so the last wait stays visible.
      if (state_d == REQ) begin
         if (state_q != REQ) begin
            wait_d = WAIT_W'(1);
         end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
         end
      end
      vp_d = (state_d == REQ);
   end

   // FSM state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         vp_q    <= 1'b0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         vp_q    <= vp_d;
         wait_q  <= wait_d;
      end
   end

   assign VehiclePresent = vp_q;
   assign WaitCycles     = wait_q;

endmodule
